width_gearbox: RTL and testbench
================================

// Module: width_gearbox
// PURPOSE
//  Parametrised unit-granular width converter (gearbox) with valid/ready on both sides and frame-end flush.
//  Packs a stream of IN_UNITS x UNIT_W words into OUT_UNITS x UNIT_W words, up- or down-sizing.
//  Sits between RAM read ports and the compute datapath, e.g. 16b DDR words -> 24b pixel (3 x QUAN_BITS) words.
//  Adds partial-word flush on i_last with byte-keep mask, and skid capacity for full-rate streaming.
// PARAMETERS
//  UNIT_W     8   bits per unit (set to `QUAN_BITS)
//  IN_UNITS   2   units per input word (>=1)
//  OUT_UNITS  3   units per output word (>=1)
//  BUF_UNITS  IN_UNITS+2*OUT_UNITS  internal capacity in units (localparam, not overridable)
// PORTS
//  s_clk        in   1                  clock
//  s_rst_n      in   1                  synchronous reset, active low
//  i_in_data    in   IN_UNITS*UNIT_W    input word, unit 0 in bits [UNIT_W-1:0] (first in stream order)
//  i_in_valid   in   1                  input word valid
//  i_in_last    in   1                  input word is final word of frame
//  o_in_ready   out  1                  block accepts input this cycle
//  o_out_data   out  OUT_UNITS*UNIT_W   output word, unit 0 in LSBs
//  o_out_keep   out  OUT_UNITS          per-unit valid mask, contiguous from bit 0
//  o_out_last   out  1                  final output word of frame
//  o_out_valid  out  1                  output word valid
//  i_out_ready  in   1                  downstream accepts output
// BEHAVIOUR
//  - One clock, s_clk. Reset synchronous active low on s_rst_n: cnt=0, last_pend=0, buffer cleared to 0.
//    While s_rst_n=0 and first cycle after: o_in_ready=0, o_out_valid=0, o_out_last=0, o_out_keep=0, o_out_data=0.
//  - Reset mid-frame discards all buffered units; no partial word is emitted.
//  - State: unit buffer buf[BUF_UNITS], occupancy cnt (0..BUF_UNITS), flag last_pend.
//  - Handshake: transfer when valid&ready on that side. valid must not depend on ready.
//    o_in_ready = !last_pend && (cnt <= BUF_UNITS-IN_UNITS); registered-state only, no comb path from i_out_ready.
//  - o_out_valid = (cnt >= OUT_UNITS) || (last_pend && cnt != 0). Data/keep/last driven from buf[0..OUT_UNITS-1] regs.
//  - o_out_keep: all ones if cnt>=OUT_UNITS, else (1<<cnt)-1. Units beyond cnt driven 0.
//  - o_out_last = last_pend && (cnt <= OUT_UNITS). Exact multiple: final full word carries last, keep all ones.
//  - Per cycle: pop first (shift buf down by popped units = min(cnt,OUT_UNITS)), then append input units
//    at position cnt-popped. Simultaneous push+pop in same cycle is required and lossless.
//  - Accepting a word with i_in_last=1 sets last_pend; cleared when the o_out_last word transfers, cnt->0,
//    o_in_ready reasserts next cycle. i_in_last with IN data only, no empty-frame flush.
//  - Latency: input transfer at cycle N -> earliest o_out_valid at N+1 (data registered once).
//  - Throughput: with i_out_ready=1 and i_in_valid=1 continuous, input never stalls when IN_UNITS<=OUT_UNITS;
//    output never bubbles when IN_UNITS>=OUT_UNITS (outside frame-end drain).
//  - cnt never exceeds BUF_UNITS; overflow/underflow impossible by construction; assert in sim.
//  - i_out_ready low holds o_out_data/keep/last/valid stable until transfer.
// TESTING  (UNIT_W=8 unless stated)
//  1) 2->3: in 0x2211,0x4433,0x6655, out_ready=1 -> out 0x332211, 0x665544, keep 3'b111, last=0, no in stall.
//  2) 2->3 flush: in 0x2211 last=1 -> one out 0x002211 keep 3'b011 last=1; in_ready low until taken.
//  3) 2->3 exact: in 0x2211,0x4433,0x6655(last) -> 2nd out 0x665544 keep 3'b111 last=1; no extra beat.
//  4) Backpressure: out_ready=0 for 10 cycles, in_valid=1 -> in_ready drops once cnt>6, all units out in order.
//  5) 3->2 downsize: in 0x332211,0x665544(last) -> out 0x2211,0x4433,0x6655 last on 3rd, keep 2'b11.
//  6) Reset mid-frame: s_rst_n=0 with cnt=4 -> next cycles valid=0, ready=0; new frame 0x2211.. as test 1.

Source files
------------

// File: rtl/width_gearbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : width_gearbox                                              |
// | Description : Unit-granular width converter with valid/ready on both     |
// |               sides. Packs IN_UNITS x UNIT_W input words into            |
// |               OUT_UNITS x UNIT_W output words. A word accepted with      |
// |               i_in_last flushes the remaining units as a final, possibly |
// |               partial, word with a per-unit keep mask.                   |
// | Ports       : s_clk        clock                                         |
// |               s_rst_n      synchronous reset, active low                 |
// |               i_in_data    input word, unit 0 in the LSBs                |
// |               i_in_valid   input word valid                              |
// |               i_in_last    input word closes the frame                   |
// |               o_in_ready   input word accepted this cycle                |
// |               o_out_data   output word, unit 0 in the LSBs               |
// |               o_out_keep   per-unit valid mask, contiguous from bit 0    |
// |               o_out_last   final output word of the frame                |
// |               o_out_valid  output word valid                             |
// |               i_out_ready  downstream accepts the output word            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module width_gearbox #(
    parameter int UNIT_W    = 8,
    parameter int IN_UNITS  = 2,
    parameter int OUT_UNITS = 3
) (
    input  logic                        s_clk,
    input  logic                        s_rst_n,
    input  logic [IN_UNITS*UNIT_W-1:0]  i_in_data,
    input  logic                        i_in_valid,
    input  logic                        i_in_last,
    output logic                        o_in_ready,
    output logic [OUT_UNITS*UNIT_W-1:0] o_out_data,
    output logic [OUT_UNITS-1:0]        o_out_keep,
    output logic                        o_out_last,
    output logic                        o_out_valid,
    input  logic                        i_out_ready
);

    // Room for one input word on top of two full output words: lets a push
    // and a pop overlap every cycle without stalling either side.
    localparam int c_BUF_UNITS = IN_UNITS + 2 * OUT_UNITS;
    localparam int c_CNT_W     = $clog2(c_BUF_UNITS + 1);
    // Shift window source is padded so buf[i + shift] never leaves the array.
    localparam int c_EXT_UNITS = c_BUF_UNITS + OUT_UNITS;

    localparam logic [c_CNT_W-1:0] c_CNT_OUT  = c_CNT_W'(OUT_UNITS);
    localparam logic [c_CNT_W-1:0] c_CNT_IN   = c_CNT_W'(IN_UNITS);
    localparam logic [c_CNT_W-1:0] c_CNT_BUF  = c_CNT_W'(c_BUF_UNITS);
    localparam logic [c_CNT_W-1:0] c_IN_LIMIT = c_CNT_W'(c_BUF_UNITS - IN_UNITS);

    logic [UNIT_W-1:0]  r_buf [c_BUF_UNITS];
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last_pend;
    // Low during reset and for the first cycle after it; holds off input.
    logic               r_run;

    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_shift;
    logic [c_CNT_W-1:0] w_base;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [UNIT_W-1:0]  w_ext      [c_EXT_UNITS];
    logic [UNIT_W-1:0]  w_buf_next [c_BUF_UNITS];

    // All handshake outputs come from registered state only.
    assign o_in_ready  = r_run && !r_last_pend && (r_cnt <= c_IN_LIMIT);
    assign o_out_valid = (r_cnt >= c_CNT_OUT) || (r_last_pend && (r_cnt != '0));
    assign o_out_last  = r_last_pend && (r_cnt <= c_CNT_OUT);

    generate
        for (genvar k = 0; k < OUT_UNITS; k++) begin : g_out_unit
            assign o_out_keep[k] = (c_CNT_W'(k) < r_cnt);
            assign o_out_data[k*UNIT_W +: UNIT_W] = o_out_keep[k] ? r_buf[k] : '0;
        end
    endgenerate

    assign w_push     = i_in_valid && o_in_ready;
    assign w_pop      = o_out_valid && i_out_ready;
    // A flush word pops fewer than OUT_UNITS units.
    assign w_shift    = !w_pop ? '0 : ((r_cnt >= c_CNT_OUT) ? c_CNT_OUT : r_cnt);
    assign w_base     = r_cnt - w_shift;
    assign w_cnt_next = w_base + (w_push ? c_CNT_IN : '0);

    generate
        for (genvar j = 0; j < c_BUF_UNITS; j++) begin : g_ext_buf
            assign w_ext[j] = r_buf[j];
        end
        for (genvar j = c_BUF_UNITS; j < c_EXT_UNITS; j++) begin : g_ext_pad
            assign w_ext[j] = '0;
        end
    endgenerate

    // Pop first (shift down, zero fill from the top), then append the
    // incoming units right behind what is left. Slots at or above the
    // occupancy therefore always hold zero.
    always_comb begin
        for (int i = 0; i < c_BUF_UNITS; i++) begin
            w_buf_next[i] = '0;
            for (int p = 0; p <= OUT_UNITS; p++) begin
                if (w_shift == c_CNT_W'(p)) begin
                    w_buf_next[i] = w_ext[i + p];
                end
            end
            for (int u = 0; u < IN_UNITS; u++) begin
                if (w_push && (c_CNT_W'(i) == (w_base + c_CNT_W'(u)))) begin
                    w_buf_next[i] = i_in_data[u*UNIT_W +: UNIT_W];
                end
            end
        end
    end

    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            r_run       <= 1'b0;
            r_cnt       <= '0;
            r_last_pend <= 1'b0;
            for (int i = 0; i < c_BUF_UNITS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            r_cnt <= w_cnt_next;
            for (int i = 0; i < c_BUF_UNITS; i++) begin
                r_buf[i] <= w_buf_next[i];
            end
            // Input is blocked while last_pend is set, so set and clear
            // can never coincide.
            if (w_push && i_in_last) begin
                r_last_pend <= 1'b1;
            end else if (w_pop && o_out_last) begin
                r_last_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst_n) begin
            assert (r_cnt <= c_CNT_BUF);
            assert (!w_push || (({1'b0, w_base} + {1'b0, c_CNT_IN}) <= {1'b0, c_CNT_BUF}));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_width_gearbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_width_gearbox                                           |
// | Description : Self-checking bench for width_gearbox. A 2->3 instance is  |
// |               compared every cycle against a unit-queue model; a 3->2    |
// |               instance covers down-sizing with literal expectations.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_width_gearbox;

    localparam int c_IN  = 2;
    localparam int c_OUT = 3;
    localparam int c_BUF = c_IN + 2 * c_OUT;

    typedef struct packed { logic [7:0] u; logic l; } unit_t;
    typedef struct packed { logic [23:0] d; logic [2:0] k; logic l; } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     = 1'b0;
    logic [15:0] in_data   = '0;
    logic        in_valid  = 1'b0;
    logic        in_last   = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [23:0] out_data;
    logic [2:0]  out_keep;
    logic        out_last;
    logic        out_valid;

    logic [23:0] b_in_data   = '0;
    logic        b_in_valid  = 1'b0;
    logic        b_in_last   = 1'b0;
    logic        b_out_ready = 1'b1;
    logic        b_in_ready;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_keep;
    logic        b_out_last;
    logic        b_out_valid;

    width_gearbox #(.UNIT_W(8), .IN_UNITS(2), .OUT_UNITS(3)) u_dut (
        .s_clk      (clk),
        .s_rst_n    (rst_n),
        .i_in_data  (in_data),
        .i_in_valid (in_valid),
        .i_in_last  (in_last),
        .o_in_ready (in_ready),
        .o_out_data (out_data),
        .o_out_keep (out_keep),
        .o_out_last (out_last),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready)
    );

    width_gearbox #(.UNIT_W(8), .IN_UNITS(3), .OUT_UNITS(2)) u_dut_down (
        .s_clk      (clk),
        .s_rst_n    (rst_n),
        .i_in_data  (b_in_data),
        .i_in_valid (b_in_valid),
        .i_in_last  (b_in_last),
        .o_in_ready (b_in_ready),
        .o_out_data (b_out_data),
        .o_out_keep (b_out_keep),
        .o_out_last (b_out_last),
        .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready)
    );

    int    checks = 0;
    int    errors = 0;
    unit_t mq[$];      // units accepted but not yet delivered, in stream order
    word_t log_q[$];   // words the model says were delivered
    word_t b_log[$];   // words seen leaving the down-sizing instance
    bit    armed    = 1'b0;
    bit    rst_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: outputs follow from the queue of pending units. A word is the
    // next OUT units, cut short right after a frame-final unit.
    always @(negedge clk) begin : p_compare
        int    n;
        bit    lp, ev, er, stop;
        word_t ew;
        unit_t un;
        n  = mq.size();
        lp = 1'b0;
        foreach (mq[j]) if (mq[j].l) lp = 1'b1;
        er = !rst_seen && !lp && (n <= c_BUF - c_IN);
        ev = !rst_seen && ((n >= c_OUT) || (lp && n != 0));
        ew   = '0;
        stop = 1'b0;
        for (int j = 0; j < c_OUT; j++) begin
            if (!stop && j < n) begin
                ew.d[j*8 +: 8] = mq[j].u;
                ew.k[j]        = 1'b1;
                if (mq[j].l) begin
                    ew.l = 1'b1;
                    stop = 1'b1;
                end
            end
        end
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                chk("out_data", 32'(out_data), 32'(ew.d));
                chk("out_keep", 32'(out_keep), 32'(ew.k));
                chk("out_last", 32'(out_last), 32'(ew.l));
            end
            if (rst_seen) begin
                chk("rst_data", 32'(out_data), 32'h0);
                chk("rst_keep", 32'(out_keep), 32'h0);
                chk("rst_last", 32'(out_last), 32'h0);
            end
        end
        if (!rst_n) begin
            mq.delete();
            rst_seen = 1'b1;
            armed    = 1'b1;
        end else if (armed) begin
            rst_seen = 1'b0;
            if (ev && out_ready) begin
                for (int j = 0; j < c_OUT; j++) if (ew.k[j]) void'(mq.pop_front());
                log_q.push_back(ew);
            end
            if (in_valid && er) begin
                for (int u = 0; u < c_IN; u++) begin
                    un.u = in_data[u*8 +: 8];
                    un.l = in_last && (u == c_IN - 1);
                    mq.push_back(un);
                end
            end
        end
    end

    always @(negedge clk) begin : p_down_log
        word_t w;
        if (rst_n && b_out_valid && b_out_ready) begin
            w   = '0;
            w.d = 24'(b_out_data);
            w.k = 3'(b_out_keep);
            w.l = b_out_last;
            b_log.push_back(w);
        end
    end

    // Waits for the pending input word to be taken; returns at posedge+1.
    task automatic wait_accept(input bit sel, output bit stalled);
        int n;
        n       = 0;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (sel ? b_in_ready : in_ready) break;
            stalled = 1'b1;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: actual no ready in 200 cycles, expected ready");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input bit l, output bit stalled);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        wait_accept(1'b0, stalled);
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (mq.size() == 0 && out_valid === 1'b0) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: actual %0d units pending, expected 0", mq.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string name, input int idx, input logic [23:0] d,
                            input logic [2:0] k, input logic l);
        if (idx < log_q.size()) begin
            chk({name, "_data"}, 32'(log_q[idx].d), 32'(d));
            chk({name, "_keep"}, 32'(log_q[idx].k), 32'(k));
            chk({name, "_last"}, 32'(log_q[idx].l), 32'(l));
        end
    endtask

    task automatic run_t1(input string tag);
        bit st;
        log_q.delete();
        out_ready = 1'b1;
        send(16'h2211, 1'b0, st); chk({tag, "_stall0"}, 32'(st), 32'h0);
        send(16'h4433, 1'b0, st); chk({tag, "_stall1"}, 32'(st), 32'h0);
        send(16'h6655, 1'b0, st); chk({tag, "_stall2"}, 32'(st), 32'h0);
        wait_idle();
        chk({tag, "_words"}, 32'(log_q.size()), 32'd2);
        chk_word({tag, "_w0"}, 0, 24'h332211, 3'b111, 1'b0);
        chk_word({tag, "_w1"}, 1, 24'h665544, 3'b111, 1'b0);
    endtask

    initial begin : p_stim
        bit st;
        bit take;
        int acc;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Steady 2->3 upsizing.
        run_t1("t1");

        // Single-word frame flushes as a partial word.
        log_q.delete();
        send(16'h2211, 1'b1, st);
        wait_idle();
        chk("t2_words", 32'(log_q.size()), 32'd1);
        chk_word("t2_w0", 0, 24'h002211, 3'b011, 1'b1);

        // Frame that is an exact multiple of the output width.
        log_q.delete();
        send(16'h2211, 1'b0, st);
        send(16'h4433, 1'b0, st);
        send(16'h6655, 1'b1, st);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("t3_words", 32'(log_q.size()), 32'd2);
        chk_word("t3_w0", 0, 24'h332211, 3'b111, 1'b0);
        chk_word("t3_w1", 1, 24'h665544, 3'b111, 1'b1);

        // Output held off for 10 cycles while input keeps coming.
        log_q.delete();
        out_ready = 1'b0;
        acc       = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = {8'(8'h11 + 2 * acc), 8'(8'h10 + 2 * acc)};
            @(negedge clk);
            take = in_ready;
            @(posedge clk);
            #1;
            if (take) acc++;
        end
        in_valid = 1'b0;
        chk("t4_accepted", 32'(acc), 32'd4);
        out_ready = 1'b1;
        send(16'h1918, 1'b1, st);
        wait_idle();
        chk("t4_words", 32'(log_q.size()), 32'd4);
        chk_word("t4_w0", 0, 24'h121110, 3'b111, 1'b0);
        chk_word("t4_w1", 1, 24'h151413, 3'b111, 1'b0);
        chk_word("t4_w2", 2, 24'h181716, 3'b111, 1'b0);
        chk_word("t4_w3", 3, 24'h000019, 3'b001, 1'b1);

        // 3->2 downsizing on the second instance.
        b_in_valid = 1'b1;
        b_in_data  = 24'h332211;
        b_in_last  = 1'b0;
        wait_accept(1'b1, st);
        b_in_data  = 24'h665544;
        b_in_last  = 1'b1;
        wait_accept(1'b1, st);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_words", 32'(b_log.size()), 32'd3);
        if (b_log.size() >= 3) begin
            chk("t5_w0_data", 32'(b_log[0].d), 32'h2211);
            chk("t5_w0_last", 32'(b_log[0].l), 32'h0);
            chk("t5_w1_data", 32'(b_log[1].d), 32'h4433);
            chk("t5_w2_data", 32'(b_log[2].d), 32'h6655);
            chk("t5_w2_keep", 32'(b_log[2].k), 32'h3);
            chk("t5_w2_last", 32'(b_log[2].l), 32'h1);
        end

        // Reset with four units buffered mid-frame.
        out_ready = 1'b0;
        send(16'h2211, 1'b0, st);
        send(16'h4433, 1'b0, st);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        run_t1("t6");

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        send(16'($urandom), 1'b1, st);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: actual still running, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
